// File: rtl/alu_pkg.sv
// Shared widths and command type for the 4-bit alu, its issue queue and the result consumer.
package alu_pkg;

  localparam int DATA_W = 4;
  localparam int OP_W   = 3;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO of alu commands with push/pop/occupancy; full/empty are decided by count.
module alu_cmd_fifo #(
  parameter type T     = alu_pkg::alu_cmd_t,
  parameter int  DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  T                 wdata_i,
  output T                 head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  T                 mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = empty_o ? T'('0) : mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/alu_cmd_queue.sv
// Issue stage for the combinational alu: buffers commands, drives the head to the alu,
// and registers each result for a downstream valid/ready consumer.
module alu_cmd_queue #(
  parameter int  DATA_W = alu_pkg::DATA_W,
  parameter int  OP_W   = alu_pkg::OP_W,
  parameter int  DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [OP_W-1:0]   in_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [OP_W-1:0]   res_op,
  output logic [CNT_W-1:0]  count
);

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } cmd_t;

  cmd_t              wcmd;
  cmd_t              head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              fire;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [OP_W-1:0]   res_op_q, res_op_d;

  assign wcmd     = '{a: in_a, b: in_b, op: in_op};
  assign in_ready = !fifo_full;
  assign push     = in_valid && in_ready;
  // A command pushed into an empty queue is not visible to fire until the next cycle.
  assign fire     = !fifo_empty && (!res_valid_q || res_ready);

  alu_cmd_fifo #(
    .T     (cmd_t),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (fire),
    .wdata_i (wcmd),
    .head_o  (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign alu_a  = head.a;
  assign alu_b  = head.b;
  assign alu_op = head.op;

  always_comb begin
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    if (fire) begin
      res_valid_d = 1'b1;
      res_data_d  = alu_out;
      res_op_d    = head.op;
    end else if (res_valid_q && res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
    end else begin
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Randomized and directed bench for alu_cmd_queue against a queue-based reference model.
module tb_alu_cmd_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a, in_b;
  logic [2:0] in_op;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_op;
  logic       res_valid, res_ready;
  logic [3:0] res_data;
  logic [2:0] res_op;
  logic [2:0] count;

  always #5 clk = ~clk;

  assign alu_out = alu_a + alu_b;

  alu_cmd_queue #(.DATA_W(4), .OP_W(3), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_op(res_op), .count(count)
  );

  typedef struct {
    int a;
    int b;
    int op;
  } cmd_s;

  cmd_s mq[$];
  int   m_vld, m_data, m_op;
  int   got_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_vld  = 0;
    m_data = 0;
    m_op   = 0;
  endtask

  // Called at the negedge with inputs applied: compare, advance the model, move to next negedge.
  task automatic step();
    int   nsz;
    bit   fire, psh;
    cmd_s c;
    #1;
    nsz = mq.size();
    check("count", count, nsz);
    check("in_ready", in_ready, (nsz != DEPTH));
    check("res_valid", res_valid, m_vld);
    check("res_data", res_data, m_data);
    check("res_op", res_op, m_op);
    check("alu_a", alu_a, nsz ? mq[0].a : 0);
    check("alu_b", alu_b, nsz ? mq[0].b : 0);
    check("alu_op", alu_op, nsz ? mq[0].op : 0);
    if (res_valid && res_ready) got_q.push_back(int'(res_data));
    fire = (nsz != 0) && (!m_vld || res_ready);
    psh  = in_valid && (nsz != DEPTH);
    if (fire) begin
      c = mq.pop_front();
      m_data = (c.a + c.b) % 16;
      m_op   = c.op;
      m_vld  = 1;
    end else if (m_vld && res_ready) begin
      m_vld = 0;
    end
    if (psh) begin
      c.a = int'(in_a); c.b = int'(in_b); c.op = int'(in_op);
      mq.push_back(c);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit v, input int a, input int b, input int op);
    in_valid = v;
    in_a     = 4'(a);
    in_b     = 4'(b);
    in_op    = 3'(op);
  endtask

  task automatic drain_until(input int n);
    for (int k = 0; k < 50 && got_q.size() < n; k++) step();
    check("drain_len", got_q.size(), n);
  endtask

  initial begin
    rst_n = 1'b0;
    res_ready = 1'b1;
    drive(0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("rst_count", count, 0);
    check("rst_res_valid", res_valid, 0);

    // 1: reset mid-stream
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(1, i + 1, 2, i); step(); end
    drive(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_count", count, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_res_data", res_data, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // 2: single command latency
    drive(1, 3, 4, 2); step();
    drive(0, 0, 0, 0); step();
    check("lat_valid", res_valid, 1);
    check("lat_data", res_data, 7);
    check("lat_op", res_op, 2);
    step();
    check("lat_valid_drop", res_valid, 0);
    step();

    // 3: wrap-around and streaming
    got_q.delete();
    drive(1, 9, 9, 5); step();
    for (int i = 0; i < 10; i++) begin drive(1, i, 1, i); step(); end
    drive(0, 0, 0, 0);
    drain_until(11);
    if (got_q.size() == 11) begin
      check("wrap_first", got_q[0], 2);
      for (int i = 1; i <= 10; i++) check("stream_order", got_q[i], i);
    end

    // 4: backpressure and full
    got_q.delete();
    res_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin drive(1, i + 2, 3, i); step(); end
    check("full_count", count, 4);
    check("full_in_ready", in_ready, 0);
    drive(0, 0, 0, 0);
    res_ready = 1'b1;
    drain_until(5);
    if (got_q.size() == 5)
      for (int i = 0; i < 5; i++) check("bp_order", got_q[i], i + 5);
    step();
    check("bp_in_ready", in_ready, 1);

    // 5: simultaneous push and pop at count=2
    got_q.delete();
    res_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin drive(1, i, 0, 0); step(); end
    drive(0, 0, 0, 0); step();
    check("pp_pre_count", count, 2);
    res_ready = 1'b1;
    drive(1, 7, 7, 1); step();
    drive(0, 0, 0, 0);
    check("pp_count", count, 2);
    drain_until(4);
    if (got_q.size() == 4) begin
      check("pp_o0", got_q[0], 0);
      check("pp_o1", got_q[1], 1);
      check("pp_o2", got_q[2], 2);
      check("pp_o3", got_q[3], 14);
    end

    // 6: empty idle
    for (int i = 0; i < 3; i++) step();
    for (int i = 0; i < 20; i++) begin
      check("idle_alu", {alu_a, alu_b, alu_op}, 0);
      check("idle_valid", res_valid, 0);
      step();
    end

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 60, $urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 7));
      res_ready = ($urandom_range(0, 99) < 55);
      step();
    end
    drive(0, 0, 0, 0);
    res_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("final_count", count, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
